// File: rtl/sample_expand.sv
// Transmit-path up-converter: buffers 22-bit I/Q samples, interpolates them by RATE
// with a 2-stage CIC, mixes them with an NCO carrier and drives an offset-binary 12-bit DAC.
module sample_expand #(
  parameter int RATE = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rstn,
  input  logic [47:0] s_sample_data,
  input  logic        s_sample_valid,
  output logic        s_sample_ready,
  input  logic [31:0] s_convert_config_data,
  output logic [11:0] m_dac_data,
  output logic        m_dac_valid,
  output logic        m_underflow
);
  localparam int LG = $clog2(RATE);
  localparam int CW = 22 + 2 * LG;

  // Handshake: a sample transfers on any cycle where s_sample_valid && s_sample_ready;
  // ready is simply "buffer empty", so the source may hold valid high indefinitely.
  logic               buf_full_q, buf_full_d;
  logic signed [21:0] i_buf_q, i_buf_d, q_buf_q, q_buf_d;
  logic [LG-1:0]      cnt_q, cnt_d;
  logic               tick;

  logic signed [CW-1:0] x_prev_q [2];
  logic signed [CW-1:0] x_prev_d [2];
  logic signed [CW-1:0] c1_prev_q [2];
  logic signed [CW-1:0] c1_prev_d [2];
  logic signed [CW-1:0] i1_q [2];
  logic signed [CW-1:0] i1_d [2];
  logic signed [CW-1:0] i2_q [2];
  logic signed [CW-1:0] i2_d [2];
  logic signed [CW-1:0] x_in [2];
  logic signed [CW-1:0] c1 [2];
  logic signed [CW-1:0] c2 [2];
  logic signed [21:0]   cic_out [2];

  logic [15:0]        p_q, p_d;
  logic signed [11:0] sin_s1_q, sin_s1_d, cos_s1_q, cos_s1_d;
  logic signed [21:0] i_s1_q, i_s1_d, q_s1_q, q_s1_d;
  logic signed [33:0] prod_i_q, prod_i_d, prod_q_q, prod_q_d;
  logic [11:0]        dac_q, dac_d;
  logic [1:0]         vcnt_q, vcnt_d;

  logic signed [34:0] y_sum;
  logic signed [13:0] y_shift;
  logic [11:0]        y_sat;
  logic               cfg_unused;

  assign cfg_unused     = ^{s_convert_config_data[31:16], s_sample_data[47:46], s_sample_data[23:22]};
  assign s_sample_ready = !buf_full_q;
  assign tick           = &cnt_q;
  assign m_underflow    = tick && !buf_full_q;
  assign m_dac_data     = dac_q;
  assign m_dac_valid    = (vcnt_q == 2'd3);

  // Quarter-wave fold of the 64-entry table round(2047*sin(2*pi*n/64)).
  function automatic logic signed [11:0] sin_lut(input logic [5:0] n);
    logic [4:0]         a;
    logic signed [11:0] m;
    a = n[4] ? (5'd16 - {1'b0, n[3:0]}) : {1'b0, n[3:0]};
    case (a)
      5'd0:    m = 12'sd0;
      5'd1:    m = 12'sd201;
      5'd2:    m = 12'sd399;
      5'd3:    m = 12'sd594;
      5'd4:    m = 12'sd783;
      5'd5:    m = 12'sd965;
      5'd6:    m = 12'sd1137;
      5'd7:    m = 12'sd1299;
      5'd8:    m = 12'sd1447;
      5'd9:    m = 12'sd1582;
      5'd10:   m = 12'sd1702;
      5'd11:   m = 12'sd1805;
      5'd12:   m = 12'sd1891;
      5'd13:   m = 12'sd1959;
      5'd14:   m = 12'sd2008;
      5'd15:   m = 12'sd2037;
      5'd16:   m = 12'sd2047;
      default: m = 12'sd0;
    endcase
    return n[5] ? -m : m;
  endfunction

  always_comb begin
    buf_full_d = buf_full_q;
    i_buf_d    = i_buf_q;
    q_buf_d    = q_buf_q;
    if (tick && buf_full_q) buf_full_d = 1'b0;
    if (s_sample_valid && s_sample_ready) begin
      buf_full_d = 1'b1;
      i_buf_d    = s_sample_data[45:24];
      q_buf_d    = s_sample_data[21:0];
    end
    cnt_d = cnt_q + 1'b1;

    // Comb section runs at the input rate; integrators run every cycle on zero-stuffed data.
    for (int r = 0; r < 2; r++) begin
      x_in[r]      = (tick && buf_full_q) ? CW'((r == 0) ? i_buf_q : q_buf_q) : '0;
      c1[r]        = x_in[r] - x_prev_q[r];
      c2[r]        = c1[r] - c1_prev_q[r];
      x_prev_d[r]  = tick ? x_in[r] : x_prev_q[r];
      c1_prev_d[r] = tick ? c1[r] : c1_prev_q[r];
      i1_d[r]      = i1_q[r] + (tick ? c2[r] : '0);
      i2_d[r]      = i2_q[r] + i1_q[r];
      cic_out[r]   = i2_q[r][LG +: 22];
    end

    p_d      = p_q + s_convert_config_data[15:0];
    sin_s1_d = sin_lut(p_q[15:10]);
    cos_s1_d = sin_lut(p_q[15:10] + 6'd16);
    i_s1_d   = cic_out[0];
    q_s1_d   = cic_out[1];
    prod_i_d = 34'(i_s1_q) * 34'(cos_s1_q);
    prod_q_d = 34'(q_s1_q) * 34'(sin_s1_q);

    y_sum   = 35'(prod_i_q) - 35'(prod_q_q);
    y_shift = 14'(y_sum >>> 21);
    if (y_shift > 14'sd2047)       y_sat = 12'h7FF;
    else if (y_shift < -14'sd2048) y_sat = 12'h800;
    else                           y_sat = y_shift[11:0];
    dac_d = y_sat ^ 12'h800;

    vcnt_d = (vcnt_q == 2'd3) ? vcnt_q : vcnt_q + 2'd1;
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      buf_full_q <= 1'b0;
      i_buf_q    <= '0;
      q_buf_q    <= '0;
      cnt_q      <= '0;
      for (int r = 0; r < 2; r++) begin
        x_prev_q[r]  <= '0;
        c1_prev_q[r] <= '0;
        i1_q[r]      <= '0;
        i2_q[r]      <= '0;
      end
      p_q      <= '0;
      sin_s1_q <= '0;
      cos_s1_q <= '0;
      i_s1_q   <= '0;
      q_s1_q   <= '0;
      prod_i_q <= '0;
      prod_q_q <= '0;
      dac_q    <= 12'h800;
      vcnt_q   <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      i_buf_q    <= i_buf_d;
      q_buf_q    <= q_buf_d;
      cnt_q      <= cnt_d;
      for (int r = 0; r < 2; r++) begin
        x_prev_q[r]  <= x_prev_d[r];
        c1_prev_q[r] <= c1_prev_d[r];
        i1_q[r]      <= i1_d[r];
        i2_q[r]      <= i2_d[r];
      end
      p_q      <= p_d;
      sin_s1_q <= sin_s1_d;
      cos_s1_q <= cos_s1_d;
      i_s1_q   <= i_s1_d;
      q_s1_q   <= q_s1_d;
      prod_i_q <= prod_i_d;
      prod_q_q <= prod_q_d;
      dac_q    <= dac_d;
      vcnt_q   <= vcnt_d;
    end
  end

endmodule
